// File: rtl/ru_route_stage.sv
// Two-lane route-tagging stage with a 2-entry skid buffer per lane ahead of the routing FIFO.
// Optional destination counters are compiled in with RU_ROUTE_STATS_EN.
module ru_route_stage #(
  parameter int RU_FIFO_WIDTH = 32,
  parameter int ROUTE_BIT     = 0
`ifdef RU_ROUTE_STATS_EN
  , parameter int CNT_WIDTH   = 16
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_route_en,
  input  logic [1:0]                 s_valid,
  input  logic [2*RU_FIFO_WIDTH-1:0] s_data,
  output logic [1:0]                 s_ready,
  output logic [1:0]                 m_valid,
  output logic [2*RU_FIFO_WIDTH-1:0] m_data,
  output logic [1:0]                 m_addr,
  input  logic [1:0]                 m_ready
`ifdef RU_ROUTE_STATS_EN
  , output logic [CNT_WIDTH-1:0]     cnt_to0
  , output logic [CNT_WIDTH-1:0]     cnt_to1
`endif
);

  localparam int W = RU_FIFO_WIDTH;

  logic [1:0]   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic [1:0]   main_addr_q, main_addr_d, skid_addr_q, skid_addr_d;
  logic [W-1:0] main_data_q [2];
  logic [W-1:0] main_data_d [2];
  logic [W-1:0] skid_data_q [2];
  logic [W-1:0] skid_data_d [2];
  logic [1:0]   s_ready_q, s_ready_d;
  logic [1:0]   acc, xfer, new_addr;

  always_comb begin
    main_vld_d  = main_vld_q;
    main_addr_d = main_addr_q;
    main_data_d = main_data_q;
    skid_vld_d  = skid_vld_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    acc         = '0;
    xfer        = '0;
    new_addr    = '0;
    for (int i = 0; i < 2; i++) begin
      acc[i]      = s_valid[i] & s_ready_q[i];
      xfer[i]     = main_vld_q[i] & m_ready[i];
      new_addr[i] = cfg_route_en ? s_data[i*W + ROUTE_BIT] : 1'(i);
      if (xfer[i] && skid_vld_q[i]) begin
        // s_ready is low while the skid is full, so no accept can collide here
        main_data_d[i] = skid_data_q[i];
        main_addr_d[i] = skid_addr_q[i];
        skid_vld_d[i]  = 1'b0;
      end else if (acc[i] && (!main_vld_q[i] || xfer[i])) begin
        main_vld_d[i]  = 1'b1;
        main_data_d[i] = s_data[i*W +: W];
        main_addr_d[i] = new_addr[i];
      end else if (acc[i]) begin
        skid_vld_d[i]  = 1'b1;
        skid_data_d[i] = s_data[i*W +: W];
        skid_addr_d[i] = new_addr[i];
      end else if (xfer[i]) begin
        main_vld_d[i]  = 1'b0;
      end
    end
    s_ready_d = ~skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_vld_q  <= '0;
      main_addr_q <= '0;
      main_data_q <= '{default: '0};
      skid_vld_q  <= '0;
      skid_addr_q <= '0;
      skid_data_q <= '{default: '0};
      s_ready_q   <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_addr_q <= main_addr_d;
      main_data_q <= main_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
      s_ready_q   <= s_ready_d;
    end
  end

  always_comb begin
    m_data = '0;
    for (int i = 0; i < 2; i++) m_data[i*W +: W] = main_data_q[i];
  end

  assign s_ready = s_ready_q;
  assign m_valid = main_vld_q;
  assign m_addr  = main_addr_q;

`ifdef RU_ROUTE_STATS_EN
  localparam int SW = CNT_WIDTH + 2;
  localparam logic [SW-1:0] CNT_MAX = {2'b00, {CNT_WIDTH{1'b1}}};

  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [1:0]           inc0, inc1;
  logic [SW-1:0]        sum0, sum1;

  always_comb begin
    inc0   = 2'(xfer[0] & ~main_addr_q[0]) + 2'(xfer[1] & ~main_addr_q[1]);
    inc1   = 2'(xfer[0] &  main_addr_q[0]) + 2'(xfer[1] &  main_addr_q[1]);
    sum0   = SW'(cnt0_q) + SW'(inc0);
    sum1   = SW'(cnt1_q) + SW'(inc1);
    cnt0_d = (sum0 > CNT_MAX) ? '1 : sum0[CNT_WIDTH-1:0];
    cnt1_d = (sum1 > CNT_MAX) ? '1 : sum1[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt_to0 = cnt0_q;
  assign cnt_to1 = cnt1_q;
`endif

endmodule

// File: tb/tb_ru_route_stage.sv
// Directed bench for ru_route_stage: reset, routing, streaming, stall/recovery, reset mid-stall,
// and destination counters when RU_ROUTE_STATS_EN is defined.
module tb_ru_route_stage;

  localparam int W = 32;
`ifdef RU_ROUTE_STATS_EN
  localparam int CW = 4;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_route_en = 1'b0;
  logic [1:0]     s_valid = 2'b00;
  logic [2*W-1:0] s_data = '0;
  logic [1:0]     s_ready;
  logic [1:0]     m_valid;
  logic [2*W-1:0] m_data;
  logic [1:0]     m_addr;
  logic [1:0]     m_ready = 2'b00;
`ifdef RU_ROUTE_STATS_EN
  logic [CW-1:0]  cnt_to0, cnt_to1;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ru_route_stage #(
    .RU_FIFO_WIDTH (W),
    .ROUTE_BIT     (0)
`ifdef RU_ROUTE_STATS_EN
    , .CNT_WIDTH   (CW)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_route_en (cfg_route_en),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_addr       (m_addr),
    .m_ready      (m_ready)
`ifdef RU_ROUTE_STATS_EN
    , .cnt_to0    (cnt_to0)
    , .cnt_to1    (cnt_to1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Streams nw words per lane (lane0 0xA000_0000+k, lane1 0xB000_0000+k) with an optional
  // m_ready=00 window; words are checked in order against the words the bench handed over.
  task automatic run_stream(input int nw, input int st_start, input int st_len,
                            output int cycles, output int xf0, output int xf1);
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] d0, d1, h;
    int idx0, idx1;
    idx0 = 0; idx1 = 0; xf0 = 0; xf1 = 0; cycles = -1;
    for (int c = 0; c < 400 && cycles < 0; c++) begin
      @(negedge clk);
      if (st_len > 0 && c > st_start && c <= st_start + st_len) begin
        chk("stall_s_ready", 64'(s_ready), 64'(2'b00));
        chk("stall_m_valid", 64'(m_valid), 64'(2'b11));
        chk("stall_hold0", 64'(m_data[W-1:0]), 64'(32'hA000_0000 + st_start - 1));
      end
      if (st_len > 0 && c == st_start + st_len + 1)
        chk("recover_s_ready", 64'(s_ready), 64'(2'b11));
      if (st_len == 0 && c > 0 && c <= nw) begin
        chk("stream_s_ready", 64'(s_ready), 64'(2'b11));
        chk("stream_m_valid", 64'(m_valid), 64'(2'b11));
      end
      m_ready = (st_len > 0 && c >= st_start && c < st_start + st_len) ? 2'b00 : 2'b11;
      if (m_valid[0] && m_ready[0]) begin
        if (q0.size() == 0) chk("lane0_spurious", 64'd1, 64'd0);
        else begin
          h = q0.pop_front();
          chk("lane0_order", 64'(m_data[W-1:0]), 64'(h));
          chk("lane0_addr", 64'(m_addr[0]), 64'(h[0]));
        end
        xf0++;
      end
      if (m_valid[1] && m_ready[1]) begin
        if (q1.size() == 0) chk("lane1_spurious", 64'd1, 64'd0);
        else begin
          h = q1.pop_front();
          chk("lane1_order", 64'(m_data[2*W-1:W]), 64'(h));
          chk("lane1_addr", 64'(m_addr[1]), 64'(h[0]));
        end
        xf1++;
      end
      d0 = 32'hA000_0000 + idx0;
      d1 = 32'hB000_0000 + idx1;
      s_valid = {idx1 < nw, idx0 < nw};
      s_data  = {d1, d0};
      if (s_valid[0] && s_ready[0]) begin q0.push_back(d0); idx0++; end
      if (s_valid[1] && s_ready[1]) begin q1.push_back(d1); idx1++; end
      if (xf0 == nw && xf1 == nw) cycles = c + 1;
    end
    s_valid = 2'b00;
    chk("stream_finished", 64'(cycles >= 0), 64'd1);
  endtask

  initial begin
    int cyc, x0, x1;

    // reset held three cycles with upstream valid
    rst_n = 1'b0; s_valid = 2'b11; s_data = {32'h1234_5678, 32'h9ABC_DEF1}; m_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_s_ready", 64'(s_ready), 64'(2'b00));
      chk("rst_m_valid", 64'(m_valid), 64'(2'b00));
      chk("rst_m_data", m_data, 64'd0);
      chk("rst_m_addr", 64'(m_addr), 64'(2'b00));
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_s_ready", 64'(s_ready), 64'(2'b11));
    chk("rel_no_accept", 64'(m_valid), 64'(2'b00));
    s_valid = 2'b00;
    @(negedge clk);

    // routing by header bit, then straight-through
    cfg_route_en = 1'b1; s_data = {32'h0000_0000, 32'h0000_0001}; s_valid = 2'b11;
    @(negedge clk);
    chk("route_m_valid", 64'(m_valid), 64'(2'b11));
    chk("route_m_addr", 64'(m_addr), 64'(2'b01));
    chk("route_m_data", m_data, {32'h0000_0000, 32'h0000_0001});
    s_valid = 2'b00;
    @(negedge clk);
    chk("route_drained", 64'(m_valid), 64'(2'b00));
    cfg_route_en = 1'b0; s_valid = 2'b11;
    @(negedge clk);
    chk("straight_m_addr", 64'(m_addr), 64'(2'b10));
    s_valid = 2'b00;
    @(negedge clk);
    cfg_route_en = 1'b1; s_data = {32'h0000_0003, 32'hA5A5_A5A4}; s_valid = 2'b11;
    @(negedge clk);
    chk("route2_m_addr", 64'(m_addr), 64'(2'b10));
    s_valid = 2'b00;
    @(negedge clk);

    // addr is latched at acceptance, later cfg changes do not affect a held word
    m_ready = 2'b00; cfg_route_en = 1'b1; s_data = {32'h0000_0000, 32'h0000_0001}; s_valid = 2'b11;
    @(negedge clk);
    chk("latch_addr_a", 64'(m_addr), 64'(2'b01));
    s_valid = 2'b00; cfg_route_en = 1'b0;
    @(negedge clk);
    chk("latch_addr_b", 64'(m_addr), 64'(2'b01));
    m_ready = 2'b11; cfg_route_en = 1'b1;
    @(negedge clk);
    chk("latch_drained", 64'(m_valid), 64'(2'b00));

    // full-rate streaming
    run_stream(100, 0, 0, cyc, x0, x1);
    chk("stream_cycles", 64'(cyc), 64'd101);
    chk("stream_xf0", 64'(x0), 64'd100);
    chk("stream_xf1", 64'(x1), 64'd100);

    // stall for four cycles and recover
    run_stream(10, 4, 4, cyc, x0, x1);
    chk("stall_cycles", 64'(cyc), 64'd15);
    chk("stall_xf0", 64'(x0), 64'd10);
    chk("stall_xf1", 64'(x1), 64'd10);

    // reset with both entries full
    @(negedge clk);
    m_ready = 2'b00; s_data = {32'hC000_0001, 32'hC000_0000}; s_valid = 2'b11;
    @(negedge clk);
    s_data = {32'hC000_0011, 32'hC000_0010};
    @(negedge clk);
    chk("full_s_ready", 64'(s_ready), 64'(2'b00));
    chk("full_m_valid", 64'(m_valid), 64'(2'b11));
    rst_n = 1'b0; s_valid = 2'b00;
    @(negedge clk);
    chk("midrst_m_valid", 64'(m_valid), 64'(2'b00));
    chk("midrst_m_data", m_data, 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'(2'b00));
    rst_n = 1'b1; m_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_stale", 64'(m_valid), 64'(2'b00));
    end
    s_data = {32'hD000_0001, 32'hD000_0000}; s_valid = 2'b11;
    @(negedge clk);
    chk("fresh_data", m_data, {32'hD000_0001, 32'hD000_0000});
    s_valid = 2'b00;
    @(negedge clk);

`ifdef RU_ROUTE_STATS_EN
    rst_n = 1'b0;
    @(negedge clk);
    chk("stats_rst0", 64'(cnt_to0), 64'd0);
    chk("stats_rst1", 64'(cnt_to1), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_route_en = 1'b1; m_ready = 2'b11;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 1) chk("stats_before", 64'(cnt_to1), 64'd0);
      if (c == 2) chk("stats_plus2", 64'(cnt_to1), 64'd2);
      if (c == 8) chk("stats_14", 64'(cnt_to1), 64'd14);
      if (c == 9) chk("stats_sat", 64'(cnt_to1), 64'd15);
      s_valid = (c < 20) ? 2'b11 : 2'b00;
      s_data  = {32'h0000_0001, 32'h0000_0001};
    end
    chk("stats_to1_final", 64'(cnt_to1), 64'd15);
    chk("stats_to0_final", 64'(cnt_to0), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
